// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output serializer: state encoding, ordering modes, bit reversal.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package fft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic MODE_BLOCK = 1'b0;
    localparam logic MODE_INTLV = 1'b1;

    // Largest supported bin-index width (1024 points).
    localparam int MAX_LOGP = 10;

    // Reverse the low w bits of v; bits at w and above come back as zero.
    function automatic logic [MAX_LOGP-1:0] bitrev(input logic [MAX_LOGP-1:0] v, input int w);
        logic [MAX_LOGP-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOGP; i++) begin
            r[i] = v[MAX_LOGP-1-i];
        end
        return r >> (MAX_LOGP - w);
    endfunction

endpackage

// File: rtl/fft_beat_map.sv
// Maps a beat number to the bin index and real/imag selector for the current frame ordering.
// Latency: purely combinational.
// Backpressure: none; the caller decides which beat to look up.
module fft_beat_map
    import fft_pkg::*;
#(
    parameter int  PTS  = 32,
    localparam int LOGP = $clog2(PTS)
) (
    input  logic [LOGP:0]   beat_i,
    input  logic            mode_i,
    input  logic            brev_i,
    output logic [LOGP-1:0] bin_o,
    output logic            type_o
);

    logic [LOGP-1:0]     j;
    logic [MAX_LOGP-1:0] rev;

    // Split the beat into (bin, type) for block or interleaved order, then optionally bit-reverse the bin.
    always_comb begin
        j      = '0;
        type_o = 1'b0;
        if (mode_i == MODE_INTLV) begin
            j      = beat_i[LOGP:1];
            type_o = beat_i[0];
        end else begin
            j      = beat_i[LOGP-1:0];
            type_o = beat_i[LOGP];
        end
        rev   = bitrev(MAX_LOGP'(j), LOGP);
        bin_o = brev_i ? rev[LOGP-1:0] : j;
    end

endmodule

// File: rtl/fft_out_serializer.sv
// Snapshots a PTS-point complex FFT result after a settle delay and streams it one word per beat.
// Latency: first word valid WAIT_CYC+1 edges after the accepted start edge; one word per cycle at full rate.
// Backpressure: ready/valid; the presented word holds stable while out_ready is low, nothing lost or repeated.
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int  N        = 16,
    parameter int  PTS      = 32,
    parameter int  WAIT_CYC = 40,
    localparam int LOGP     = $clog2(PTS)
) (
    input  logic            clk2,
    input  logic            rst_n,
    input  logic            start_output,
    input  logic            mode,
    input  logic            brev,
    input  logic            abort,
    input  logic [PTS*N-1:0] in_r_bus,
    input  logic [PTS*N-1:0] in_i_bus,
    input  logic            out_ready,
    output logic [N-1:0]    serial_out,
    output logic            out_valid,
    output logic            out_type,
    output logic [LOGP-1:0] out_index,
    output logic            output_busy,
    output logic            output_done,
    output logic            start_err
);

    localparam logic [15:0]   WAIT_LAST = 16'(WAIT_CYC - 1);
    localparam logic [LOGP:0] BEAT_LAST = (LOGP+1)'(2*PTS - 1);
    localparam logic [LOGP:0] BEAT_ONE  = (LOGP+1)'(1);

    state_t          state_q;
    logic [15:0]     wait_cnt_q;
    logic [LOGP:0]   beat_q;
    logic            mode_q;
    logic            brev_q;
    logic [PTS*N-1:0] snap_r_q;
    logic [PTS*N-1:0] snap_i_q;

    logic [N-1:0]    serial_out_q;
    logic            out_valid_q;
    logic            out_type_q;
    logic [LOGP-1:0] out_index_q;
    logic            output_busy_q;
    logic            output_done_q;
    logic            start_err_q;

    logic [LOGP:0]   map_beat;
    logic [LOGP-1:0] map_bin;
    logic            map_type;
    logic [N-1:0]    word_d;
    int              base;

    // Beat being prepared for the output register: beat 0 while loading, otherwise the one after the current.
    always_comb begin
        map_beat = '0;
        if (state_q == ST_STREAM) begin
            map_beat = beat_q + BEAT_ONE;
        end
    end

    fft_beat_map #(
        .PTS (PTS)
    ) u_beat_map (
        .beat_i (map_beat),
        .mode_i (mode_q),
        .brev_i (brev_q),
        .bin_o  (map_bin),
        .type_o (map_type)
    );

    // Fetch the next word: straight from the buses on the load cycle (snapshot not yet written), else from the snapshot.
    always_comb begin
        word_d = '0;
        base   = int'(map_bin) * N;
        if (state_q == ST_LOAD) begin
            word_d = map_type ? in_i_bus[base +: N] : in_r_bus[base +: N];
        end else begin
            word_d = map_type ? snap_i_q[base +: N] : snap_r_q[base +: N];
        end
    end

    // Snapshot capture; contents are don't-care until the first load so no reset is needed.
    always_ff @(posedge clk2) begin
        if (state_q == ST_LOAD) begin
            snap_r_q <= in_r_bus;
            snap_i_q <= in_i_bus;
        end
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            beat_q        <= '0;
            mode_q        <= MODE_BLOCK;
            brev_q        <= 1'b0;
            serial_out_q  <= '0;
            out_valid_q   <= 1'b0;
            out_type_q    <= 1'b0;
            out_index_q   <= '0;
            output_busy_q <= 1'b0;
            output_done_q <= 1'b0;
            start_err_q   <= 1'b0;
        end else begin
            start_err_q   <= start_output && (state_q != ST_IDLE);
            output_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_output && !abort) begin
                        state_q       <= ST_WAIT;
                        wait_cnt_q    <= '0;
                        mode_q        <= mode;
                        brev_q        <= brev;
                        output_busy_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state_q       <= ST_IDLE;
                        out_valid_q   <= 1'b0;
                        output_busy_q <= 1'b0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= ST_LOAD;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_q       <= ST_IDLE;
                        out_valid_q   <= 1'b0;
                        output_busy_q <= 1'b0;
                    end else begin
                        serial_out_q <= word_d;
                        out_type_q   <= map_type;
                        out_index_q  <= map_bin;
                        out_valid_q  <= 1'b1;
                        beat_q       <= '0;
                        state_q      <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        state_q       <= ST_IDLE;
                        out_valid_q   <= 1'b0;
                        output_busy_q <= 1'b0;
                    end else if (out_valid_q && out_ready) begin
                        if (beat_q == BEAT_LAST) begin
                            out_valid_q   <= 1'b0;
                            output_busy_q <= 1'b0;
                            output_done_q <= 1'b1;
                            state_q       <= ST_DONE;
                        end else begin
                            beat_q       <= map_beat;
                            serial_out_q <= word_d;
                            out_type_q   <= map_type;
                            out_index_q  <= map_bin;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q       <= ST_IDLE;
                    out_valid_q   <= 1'b0;
                    output_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign serial_out  = serial_out_q;
    assign out_valid   = out_valid_q;
    assign out_type    = out_type_q;
    assign out_index   = out_index_q;
    assign output_busy = output_busy_q;
    assign output_done = output_done_q;
    assign start_err   = start_err_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Scoreboard bench for fft_out_serializer: a 32-point instance and an 8-point interleaved/bit-reversed instance.
// Expected beats are queued when a frame is requested; negedge monitors pop and compare on each transfer.
// Backpressure, abort, start_err, snapshot isolation and mid-frame reset are exercised by directed sequences.
module tb_fft_out_serializer;

    localparam int N   = 16;
    localparam int PTS = 32;
    localparam int WC  = 40;
    localparam int P8  = 8;
    localparam int WC8 = 2;

    logic clk2 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk2 = ~clk2;

    // 32-point instance
    logic             start_output, mode, brev, abort, out_ready;
    logic [PTS*N-1:0] in_r_bus, in_i_bus;
    logic [N-1:0]     serial_out;
    logic             out_valid, out_type, output_busy, output_done, start_err;
    logic [4:0]       out_index;

    // 8-point instance
    logic             start_b, mode_b, brev_b, abort_b, ready_b;
    logic [P8*N-1:0]  in_r_b, in_i_b;
    logic [N-1:0]     serial_b;
    logic             valid_b, type_b, busy_b, done_b, err_b;
    logic [2:0]       index_b;

    fft_out_serializer #(.N(N), .PTS(PTS), .WAIT_CYC(WC)) dut (
        .clk2(clk2), .rst_n(rst_n), .start_output(start_output), .mode(mode), .brev(brev),
        .abort(abort), .in_r_bus(in_r_bus), .in_i_bus(in_i_bus), .out_ready(out_ready),
        .serial_out(serial_out), .out_valid(out_valid), .out_type(out_type), .out_index(out_index),
        .output_busy(output_busy), .output_done(output_done), .start_err(start_err)
    );

    fft_out_serializer #(.N(N), .PTS(P8), .WAIT_CYC(WC8)) dut8 (
        .clk2(clk2), .rst_n(rst_n), .start_output(start_b), .mode(mode_b), .brev(brev_b),
        .abort(abort_b), .in_r_bus(in_r_b), .in_i_bus(in_i_b), .out_ready(ready_b),
        .serial_out(serial_b), .out_valid(valid_b), .out_type(type_b), .out_index(index_b),
        .output_busy(busy_b), .output_done(done_b), .start_err(err_b)
    );

    typedef struct {
        logic [15:0] d;
        logic        t;
        logic [4:0]  i;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   total = 0;
    int   bad = 0;
    int   xfer_a = 0;
    int   xfer_b = 0;
    logic bp_en = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int   bp_ph = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor for the 32-point instance: hold-stability while stalled, and scoreboard compare on transfer.
    logic        hold_a = 1'b0;
    logic [15:0] hd;
    logic        ht;
    logic [4:0]  hi;
    always @(negedge clk2) begin
        exp_t e;
        if (!rst_n) begin
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                chk("hold_data", serial_out, hd);
                chk("hold_index", out_index, hi);
                chk("hold_type", out_type, ht);
                chk("hold_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                if (sb_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat_a: got data %0d index %0d with nothing expected", serial_out, out_index);
                end else begin
                    e = sb_a.pop_front();
                    chk("beat_data", serial_out, e.d);
                    chk("beat_type", out_type, e.t);
                    chk("beat_index", out_index, e.i);
                end
                xfer_a++;
            end
            hold_a = out_valid && !out_ready && !abort;
            hd = serial_out;
            ht = out_type;
            hi = out_index;
        end
    end

    // Monitor for the 8-point instance.
    always @(negedge clk2) begin
        exp_t e;
        if (rst_n && valid_b && ready_b) begin
            if (sb_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat_b: got data %0d index %0d with nothing expected", serial_b, index_b);
            end else begin
                e = sb_b.pop_front();
                chk("b_data", serial_b, e.d);
                chk("b_type", type_b, e.t);
                chk("b_index", index_b, e.i);
            end
            xfer_b++;
        end
    end

    task automatic step();
        @(posedge clk2);
        #1;
        if (bp_en) begin
            out_ready = bp_pat[bp_ph];
            bp_ph = (bp_ph + 1) % 4;
        end
    endtask

    task automatic fill_a();
        for (int k = 0; k < PTS; k++) begin
            in_r_bus[k*N +: N] = 16'(k);
            in_i_bus[k*N +: N] = 16'(100 + k);
        end
    endtask

    // Block order: real 0..31 then imag 100..131.
    task automatic push_block(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.t = (k >= PTS);
            e.i = 5'(k % PTS);
            e.d = (k < PTS) ? 16'(k) : 16'(100 + k - PTS);
            sb_a.push_back(e);
        end
    endtask

    // Interleaved order: re(j), im(j) per bin.
    task automatic push_intlv();
        exp_t e;
        for (int k = 0; k < 2*PTS; k++) begin
            e.i = 5'(k / 2);
            e.t = k[0];
            e.d = e.t ? 16'(100 + k/2) : 16'(k/2);
            sb_a.push_back(e);
        end
    endtask

    // Request a frame; mode/brev are flipped right after acceptance to prove they were latched.
    task automatic start_frame(input logic m, input logic b);
        mode = m;
        brev = b;
        start_output = 1'b1;
        step();
        start_output = 1'b0;
        mode = ~m;
        brev = ~b;
        chk("busy_after_start", output_busy, 1);
    endtask

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        while (!out_valid && c < 200) begin
            step();
            c++;
        end
        if (!out_valid) timeout_fail(name);
    endtask

    task automatic wait_done(input string name, input int init, output int vcnt);
        int c;
        c = 0;
        vcnt = init;
        while (!output_done && c < 1000) begin
            step();
            c++;
            if (!output_done && out_valid) vcnt++;
        end
        if (!output_done) timeout_fail(name);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c;
        int   vcnt;
        logic seen;
        logic [2:0] idx8 [16];
        exp_t e;

        start_output = 0; mode = 0; brev = 0; abort = 0; out_ready = 1;
        start_b = 0; mode_b = 0; brev_b = 0; abort_b = 0; ready_b = 1;
        fill_a();
        for (int k = 0; k < P8; k++) begin
            in_r_b[k*N +: N] = 16'(10 + k);
            in_i_b[k*N +: N] = 16'(50 + k);
        end

        // Reset state
        repeat (3) @(posedge clk2);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", output_busy, 0);
        chk("rst_done", output_done, 0);
        chk("rst_err", start_err, 0);
        chk("rst_data", serial_out, 0);
        chk("rst_index", out_index, 0);
        step();

        // Block mode, full rate: latency, contiguity, done timing
        xfer_a = 0;
        push_block(2*PTS);
        start_frame(1'b0, 1'b0);
        c = 0;
        while (!out_valid && c < 200) begin
            step();
            c++;
        end
        chk("first_valid_edge", c, WC + 1);
        wait_done("full_rate_done", 1, vcnt);
        chk("full_rate_valid_cycles", vcnt, 2*PTS);
        chk("full_rate_xfers", xfer_a, 2*PTS);
        chk("full_rate_sb_empty", sb_a.size(), 0);
        chk("done_valid_low", out_valid, 0);
        chk("done_busy_low", output_busy, 0);
        step();
        chk("done_one_cycle", output_done, 0);

        // Backpressure 1,0,0,1 with bus change after load and a stray start mid-stream
        xfer_a = 0;
        bp_ph = 0;
        bp_en = 1'b1;
        push_block(2*PTS);
        start_frame(1'b0, 1'b0);
        wait_valid("bp_valid");
        in_r_bus = '1;
        in_i_bus = '1;
        repeat (5) step();
        start_output = 1'b1;
        step();
        start_output = 1'b0;
        chk("start_err_pulse", start_err, 1);
        step();
        chk("start_err_clear", start_err, 0);
        wait_done("bp_done", 0, vcnt);
        chk("bp_xfers", xfer_a, 2*PTS);
        chk("bp_sb_empty", sb_a.size(), 0);
        bp_en = 1'b0;
        out_ready = 1'b1;
        fill_a();
        step();

        // Abort at beat 10
        xfer_a = 0;
        push_block(10);
        start_frame(1'b0, 1'b0);
        wait_valid("abort_valid");
        repeat (10) step();
        abort = 1'b1;
        out_ready = 1'b0;
        step();
        abort = 1'b0;
        chk("abort_valid_low", out_valid, 0);
        chk("abort_busy_low", output_busy, 0);
        seen = 1'b0;
        repeat (5) begin
            step();
            if (output_done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_xfers", xfer_a, 10);
        chk("abort_sb_empty", sb_a.size(), 0);
        out_ready = 1'b1;

        // New start after abort, interleaved order
        xfer_a = 0;
        push_intlv();
        start_frame(1'b1, 1'b0);
        wait_valid("intlv_valid");
        wait_done("intlv_done", 1, vcnt);
        chk("intlv_xfers", xfer_a, 2*PTS);
        chk("intlv_sb_empty", sb_a.size(), 0);
        step();

        // 8-point interleaved + bit-reversed
        idx8 = '{3'd0, 3'd0, 3'd4, 3'd4, 3'd2, 3'd2, 3'd6, 3'd6,
                 3'd1, 3'd1, 3'd5, 3'd5, 3'd3, 3'd3, 3'd7, 3'd7};
        for (int k = 0; k < 16; k++) begin
            e.i = {2'b00, idx8[k]};
            e.t = k[0];
            e.d = e.t ? 16'(50 + int'(idx8[k])) : 16'(10 + int'(idx8[k]));
            sb_b.push_back(e);
        end
        xfer_b = 0;
        mode_b = 1'b1;
        brev_b = 1'b1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        mode_b = 1'b0;
        brev_b = 1'b0;
        c = 0;
        while (!done_b && c < 200) begin
            step();
            c++;
        end
        if (!done_b) timeout_fail("brev8_done");
        chk("brev8_xfers", xfer_b, 16);
        chk("brev8_sb_empty", sb_b.size(), 0);

        // Asynchronous reset mid-stream
        xfer_a = 0;
        push_block(5);
        start_frame(1'b0, 1'b0);
        wait_valid("rst_mid_valid");
        repeat (5) step();
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", output_busy, 0);
        chk("midrst_data", serial_out, 0);
        chk("midrst_index", out_index, 0);
        chk("midrst_type", out_type, 0);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            step();
            if (output_done || out_valid || output_busy) seen = 1'b1;
        end
        chk("midrst_stays_idle", seen, 0);
        chk("midrst_xfers", xfer_a, 5);
        chk("midrst_sb_empty", sb_a.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
